fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/spi_com_pkg.sv | 13 +
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/spi_com_pkg.sv
// Shared constants and the FSM state encoding for the FIFO write-port arbiter.
package spi_com_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_MAX_BURST = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin burst arbiter for a shared FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add the cnt0/cnt1/stall_cnt statistics outputs.
module fifo_wr_arbiter
    import spi_com_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    output logic              fifo_wreq,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic              fifo_wfull,
    output logic [1:0]        grant
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]       cnt0,
    output logic [15:0]       cnt1,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [7:0] LAST_WORD = 8'(MAX_BURST - 1);

    arb_state_t r_state;
    logic       r_rr;
    logic [7:0] r_burst_cnt;

    logic       w_own_valid;
    logic       w_oth_valid;
    logic       w_accept;
    logic       w_release;
    arb_state_t w_other_gnt;

    always_comb begin
        w_own_valid = 1'b0;
        w_oth_valid = 1'b0;
        w_other_gnt = IDLE;
        fifo_wdata  = '0;
        case (r_state)
            GNT0: begin
                w_own_valid = s0_valid;
                w_oth_valid = s1_valid;
                w_other_gnt = GNT1;
                fifo_wdata  = s0_data;
            end
            GNT1: begin
                w_own_valid = s1_valid;
                w_oth_valid = s0_valid;
                w_other_gnt = GNT0;
                fifo_wdata  = s1_data;
            end
            default: ;
        endcase
    end

    // rst gates acceptance so nothing is written while a burst is being abandoned
    assign w_accept  = w_own_valid && !fifo_wfull && !rst;
    assign w_release = !w_own_valid || (w_accept && (r_burst_cnt == LAST_WORD));

    assign fifo_wreq = w_accept;
    assign s0_ready  = w_accept && (r_state == GNT0);
    assign s1_ready  = w_accept && (r_state == GNT1);
    assign grant     = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr        <= 1'b1;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_burst_cnt <= '0;
                    if (s0_valid && (!s1_valid || r_rr)) begin
                        r_state <= GNT0;
                    end else if (s1_valid) begin
                        r_state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (w_release) begin
                        r_rr        <= (r_state == GNT1);
                        r_burst_cnt <= '0;
                        // a lone owner that exhausted its burst is re-granted in place
                        if (w_oth_valid) begin
                            r_state <= w_other_gnt;
                        end else if (!w_own_valid) begin
                            r_state <= IDLE;
                        end
                    end else if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0      <= '0;
            r_cnt1      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (s0_ready) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (s1_ready) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
            if (w_own_valid && fifo_wfull && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign cnt0      = r_cnt0;
    assign cnt1      = r_cnt1;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
